// File: rtl/aes_decipher_block.sv
// aes_decipher_block: iterative AES-128 inverse cipher, one inverse round per clock; define AES_DEC_BUSY_ERR_EN for the sticky busy_err flag
module aes_decipher_block (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [127:0] round_key_0,
    input  logic [127:0] round_key_1,
    input  logic [127:0] round_key_2,
    input  logic [127:0] round_key_3,
    input  logic [127:0] round_key_4,
    input  logic [127:0] round_key_5,
    input  logic [127:0] round_key_6,
    input  logic [127:0] round_key_7,
    input  logic [127:0] round_key_8,
    input  logic [127:0] round_key_9,
    input  logic [127:0] round_key_10,
    input  logic         key_ready,
    input  logic         start,
    input  logic [127:0] input_block,
    output logic [127:0] old_inv_sbox,
    input  logic [127:0] new_inv_sbox,
    output logic [127:0] output_block,
    output logic         ready,
    output logic         valid,
    output logic         busy_err
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_e;
    fsm_e fsm_q, fsm_d;
    logic [127:0] state_q, state_d, out_q, out_d, rk_sel;
    logic [3:0] rnd_q, rnd_d;
    logic valid_q, valid_d, accept;

    // xtime applied to all four byte lanes of a column at once
    function automatic logic [31:0] xt4(input logic [31:0] w);
        logic [31:0] h;
        h = (w >> 7) & 32'h0101_0101;
        return ((w & 32'h7f7f_7f7f) << 1) ^ (h << 4) ^ (h << 3) ^ (h << 1) ^ h;
    endfunction

    // lane i = 0e*a[i] ^ 0b*a[i+1] ^ 0d*a[i+2] ^ 09*a[i+3]; byte rotations align the lanes
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [31:0] x2, x4, x8, me, mb, md, m9;
        x2 = xt4(c);
        x4 = xt4(x2);
        x8 = xt4(x4);
        me = x8 ^ x4 ^ x2;
        mb = x8 ^ x2 ^ c;
        md = x8 ^ x4 ^ c;
        m9 = x8 ^ c;
        return me ^ {mb[23:0], mb[31:24]} ^ {md[15:0], md[31:16]} ^ {m9[7:0], m9[31:8]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]), inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
    endfunction

    // row r rotates right by r bytes: out(r,c) = in(r,c-r)
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    assign ready        = (fsm_q == IDLE);
    assign accept       = ready && key_ready && start;
    assign valid        = valid_q;
    assign output_block = out_q;
    assign old_inv_sbox = inv_shift_rows(state_q);

    // round key select on rnd; codes above 10 never occur and fall back to key 0
    always_comb begin
        case (rnd_q)
            4'd1:    rk_sel = round_key_1;
            4'd2:    rk_sel = round_key_2;
            4'd3:    rk_sel = round_key_3;
            4'd4:    rk_sel = round_key_4;
            4'd5:    rk_sel = round_key_5;
            4'd6:    rk_sel = round_key_6;
            4'd7:    rk_sel = round_key_7;
            4'd8:    rk_sel = round_key_8;
            4'd9:    rk_sel = round_key_9;
            4'd10:   rk_sel = round_key_10;
            default: rk_sel = round_key_0;
        endcase
    end

    // FSM next state and datapath: initial whitening, nine full inverse rounds, last round without InvMixColumns
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rnd_d   = rnd_q;
        out_d   = out_q;
        valid_d = 1'b0;
        case (fsm_q)
            IDLE: if (accept) begin
                state_d = input_block ^ round_key_10;
                rnd_d   = 4'd9;
                fsm_d   = ROUND;
            end
            ROUND: begin
                state_d = inv_mix_columns(new_inv_sbox ^ rk_sel);
                if (rnd_q == 4'd1) fsm_d = FINAL;
                else rnd_d = rnd_q - 4'd1;
            end
            FINAL: begin
                out_d   = new_inv_sbox ^ round_key_0;
                valid_d = 1'b1;
                fsm_d   = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // state registers; reset discards any block in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rnd_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rnd_q   <= rnd_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

`ifdef AES_DEC_BUSY_ERR_EN
    logic busy_err_q, busy_err_d;

    // start while busy sets the flag; an accepted start clears it and takes priority
    always_comb busy_err_d = accept ? 1'b0 : (busy_err_q || (start && !ready));

    // sticky error flag register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) busy_err_q <= 1'b0;
        else busy_err_q <= busy_err_d;
    end

    assign busy_err = busy_err_q;
`else
    assign busy_err = 1'b0;
`endif
endmodule

// File: tb/tb_aes_decipher_block.sv
// tb_aes_decipher_block: self-checking bench with inverse S-box bank, key expansion and reference AES encryptor
module tb_aes_decipher_block;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
`ifdef AES_DEC_BUSY_ERR_EN
    localparam logic BE = 1'b1;
`else
    localparam logic BE = 1'b0;
`endif

    logic clk = 1'b0, reset_n = 1'b0, key_ready = 1'b1, start = 1'b0;
    logic [127:0] rk [11];
    logic [127:0] input_block = '0, old_inv_sbox, new_inv_sbox, output_block, want;
    logic ready, valid, busy_err;
    logic [7:0] sbox [256];
    logic [7:0] isb [256];
    logic [127:0] q [$];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 16; g++) begin : g_isb
        assign new_inv_sbox[127-8*g -: 8] = isb[old_inv_sbox[127-8*g -: 8]];
    end

    aes_decipher_block dut (
        .clk(clk), .reset_n(reset_n),
        .round_key_0(rk[0]), .round_key_1(rk[1]), .round_key_2(rk[2]), .round_key_3(rk[3]),
        .round_key_4(rk[4]), .round_key_5(rk[5]), .round_key_6(rk[6]), .round_key_7(rk[7]),
        .round_key_8(rk[8]), .round_key_9(rk[9]), .round_key_10(rk[10]),
        .key_ready(key_ready), .start(start), .input_block(input_block),
        .old_inv_sbox(old_inv_sbox), .new_inv_sbox(new_inv_sbox),
        .output_block(output_block), .ready(ready), .valid(valid), .busy_err(busy_err)
    );

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic init_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
            sbox[x] = s;
            isb[s] = 8'(x);
        end
    endtask

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] s, t;
        logic [7:0] a0, a1, a2, a3;
        s = pt ^ rk[0];
        for (int r = 1; r <= 10; r++) begin
            t = '0;
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[127-8*(4*c+w) -: 8] = sbox[s[127-8*(4*((c+w)%4)+w) -: 8]];
            if (r < 10)
                for (int c = 0; c < 4; c++) begin
                    {a0, a1, a2, a3} = t[127-32*c -: 32];
                    t[127-32*c -: 32] = {gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3,
                                         a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3,
                                         a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03),
                                         gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02)};
                end
            s = t ^ rk[r];
        end
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic send(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt);
        set_key(key);
        input_block = ct;
        start = 1'b1;
        q.push_back(pt);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (valid) begin n = k; break; end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", ready); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid); end
        checks++; if (busy_err !== 1'b0) begin errors++; $display("FAIL rst_busy_err: got %b want 0", busy_err); end
        checks++; if (output_block !== '0) begin errors++; $display("FAIL rst_output: got %h want 0", output_block); end
        checks++; if (old_inv_sbox !== '0) begin errors++; $display("FAIL rst_old_inv_sbox: got %h want 0", old_inv_sbox); end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fips_b();
        int n;
        send(KB, CB, PB);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b_ready_busy: got %b want 0", ready); end
        wait_valid(n);
        checks++; if (n != 10) begin errors++; $display("FAIL b_latency: got %0d want 10", n); end
        want = q.size() ? q.pop_front() : 'x;
        checks++; if (output_block !== want) begin errors++; $display("FAIL b_plaintext: got %h want %h", output_block, want); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b_ready_done: got %b want 1", ready); end
        @(posedge clk); #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b_valid_pulse: got %b want 0", valid); end
        checks++; if (output_block !== PB) begin errors++; $display("FAIL b_output_hold: got %h want %h", output_block, PB); end
    endtask

    task automatic test_back_to_back();
        int n;
        send(KC, CC, PC);
        wait_valid(n);
        checks++; if (n != 10) begin errors++; $display("FAIL c_latency: got %0d want 10", n); end
        want = q.size() ? q.pop_front() : 'x;
        checks++; if (output_block !== want) begin errors++; $display("FAIL c_plaintext: got %h want %h", output_block, want); end
        send(KB, CB, PB);
        wait_valid(n);
        checks++; if (n + 1 != 11) begin errors++; $display("FAIL b2b_spacing: got %0d want 11", n + 1); end
        want = q.size() ? q.pop_front() : 'x;
        checks++; if (output_block !== want) begin errors++; $display("FAIL b2b_plaintext: got %h want %h", output_block, want); end
    endtask

    task automatic test_key_ready();
        int n;
        key_ready = 1'b0;
        set_key(KC);
        input_block = CC;
        start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL kr_ready: got %b want 1", ready); end
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL kr_valid: got %b want 0", valid); end
            checks++; if (busy_err !== 1'b0) begin errors++; $display("FAIL kr_busy_err: got %b want 0", busy_err); end
        end
        key_ready = 1'b1;
        q.push_back(PC);
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL kr_accept: got ready %b want 0", ready); end
        wait_valid(n);
        checks++; if (n != 10) begin errors++; $display("FAIL kr_latency: got %0d want 10", n); end
        want = q.size() ? q.pop_front() : 'x;
        checks++; if (output_block !== want) begin errors++; $display("FAIL kr_plaintext: got %h want %h", output_block, want); end
    endtask

    task automatic test_busy();
        int n;
        send(KB, CB, PB);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 4) begin
                checks++; if (busy_err !== BE) begin errors++; $display("FAIL busy_set: got %b want %b", busy_err, BE); end
            end
            if (valid) begin n = k; break; end
            start = (k == 3 || k == 7);
            if (start) input_block = rnd128();
        end
        start = 1'b0;
        checks++; if (n != 10) begin errors++; $display("FAIL busy_latency: got %0d want 10", n); end
        want = q.size() ? q.pop_front() : 'x;
        checks++; if (output_block !== want) begin errors++; $display("FAIL busy_plaintext: got %h want %h", output_block, want); end
        checks++; if (busy_err !== BE) begin errors++; $display("FAIL busy_sticky: got %b want %b", busy_err, BE); end
        send(KC, CC, PC);
        checks++; if (busy_err !== 1'b0) begin errors++; $display("FAIL busy_clear: got %b want 0", busy_err); end
        wait_valid(n);
        want = q.size() ? q.pop_front() : 'x;
        checks++; if (output_block !== want) begin errors++; $display("FAIL busy_next_plaintext: got %h want %h", output_block, want); end
    endtask

    task automatic test_reset_mid();
        int n, seen;
        send(KB, CB, PB);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        void'(q.pop_back());
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mrst_ready: got %b want 1", ready); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b want 0", valid); end
        checks++; if (output_block !== '0) begin errors++; $display("FAIL mrst_output: got %h want 0", output_block); end
        checks++; if (busy_err !== 1'b0) begin errors++; $display("FAIL mrst_busy_err: got %b want 0", busy_err); end
        checks++; if (old_inv_sbox !== '0) begin errors++; $display("FAIL mrst_old_inv_sbox: got %h want 0", old_inv_sbox); end
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mrst_no_valid: got %0d pulses want 0", seen); end
        send(KB, CB, PB);
        wait_valid(n);
        checks++; if (n != 10) begin errors++; $display("FAIL mrst_latency: got %0d want 10", n); end
        want = q.size() ? q.pop_front() : 'x;
        checks++; if (output_block !== want) begin errors++; $display("FAIL mrst_plaintext: got %h want %h", output_block, want); end
    endtask

    task automatic test_round_trip();
        int n;
        logic [127:0] key, pt, ct;
        for (int i = 0; i < 100; i++) begin
            key = rnd128();
            pt = rnd128();
            set_key(key);
            ct = encrypt(pt);
            send(key, ct, pt);
            wait_valid(n);
            checks++; if (n != 10) begin errors++; $display("FAIL rt_latency[%0d]: got %0d want 10", i, n); end
            want = q.size() ? q.pop_front() : 'x;
            checks++; if (output_block !== want) begin errors++; $display("FAIL rt_plaintext[%0d]: got %h want %h", i, output_block, want); end
        end
    endtask

    initial begin
        init_sbox();
        set_key(KB);
        test_reset();
        test_fips_b();
        test_back_to_back();
        test_key_ready();
        test_busy();
        test_reset_mid();
        test_round_trip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/aes_decipher_block.md
# aes_decipher_block

Iterative AES-128 inverse cipher (FIPS-197 §5.3): one 128-bit ciphertext block in, one plaintext block out, one inverse round per clock. It is the receive-side counterpart of `aes_encipher_block`. It takes all eleven round keys in parallel from `aes_keymap` and does InvSubBytes through an external shared inverse S-box bank over an `old_inv_sbox`/`new_inv_sbox` port pair. Start/ready/valid handshake; 10-cycle latency.

## Interface
- No parameters (AES-128 only; Nr = 10 fixed).
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `round_key_0` … `round_key_10`  in  128 each  expanded keys from `aes_keymap`; must be stable while `ready`=0
- `key_ready`  in  1  `aes_keymap` ready; `start` is ignored while 0
- `start`  in  1  request; sampled only when `ready`=1 and `key_ready`=1
- `input_block`  in  128  ciphertext, sampled with accepted `start`
- `old_inv_sbox`  out  128  bytes to the external inverse S-box = InvShiftRows(state)
- `new_inv_sbox`  in  128  InvSBox of each byte of `old_inv_sbox`, combinational return
- `output_block`  out  128  plaintext, registered
- `ready`  out  1  idle, can accept `start`
- `valid`  out  1  one-cycle pulse when `output_block` updates
- `busy_err`  out  1  sticky protocol-error flag (see Configuration)

## Operation
- Byte order follows FIPS-197: byte 0 = bits [127:120]. The state is column-major, so column c is bits [127-32c -: 32] and row r is byte r of each column.
- FSM states: IDLE, ROUND, FINAL.
- IDLE: `ready`=1. On accepted `start`: state ← `input_block` ^ `round_key_10`; rnd ← 9; go to ROUND.
- ROUND (rnd = 9 down to 1): state ← InvMixColumns(`new_inv_sbox` ^ round_key_rnd). If rnd=1, go to FINAL; otherwise rnd ← rnd−1.
- FINAL: `output_block` ← `new_inv_sbox` ^ `round_key_0`; `valid` ← 1; go to IDLE.
- InvShiftRows: row r rotates right by r bytes.
- InvMixColumns per column uses matrix rows {0e,0b,0d,09}, cyclically shifted. Multiplication is in GF(2^8) with reduction polynomial 0x11b, built from xtime chains; no multipliers.
- Round key select is a mux on the 4-bit rnd (values 0–10). Values above 10 are unreachable; they select `round_key_0`.
- `start` while `ready`=0 is ignored; the block in flight is not disturbed.
- `start` while `key_ready`=0 is ignored and is not an error.
- `output_block` holds its value until the next FINAL.

## Timing
- Reset values: `ready`=1, `valid`=0, `busy_err`=0, `output_block`=0, state=0, rnd=0, FSM=IDLE. `old_inv_sbox` = InvShiftRows(0) = 0.
- Accepted `start` at edge E0 → `ready`=0 after E0. ROUND runs E1–E9; FINAL is at E10.
- After E10: `valid`=1 for exactly one cycle, `ready`=1, and `output_block` holds the new value.
- Latency is 10 clocks from the accepting edge to `valid`. Throughput is one block per 11 cycles at best, since `start` can be accepted in the same cycle `valid`=1 (`ready` is already 1).
- Asserting `reset_n`=0 at any point, including mid-ROUND, immediately forces all reset values. The partial block is discarded and no `valid` is issued.
- The external S-box path is purely combinational: `old_inv_sbox` → `new_inv_sbox` → register, within one cycle.

## Configuration
- `AES_DEC_BUSY_ERR_EN` defined:
  - `busy_err` is set on any cycle with `start`=1 and `ready`=0.
  - It stays set until reset, or until the next accepted `start`, which clears it in the same edge.
  - If a set and a clear occur in the same cycle, the clear wins.
- Not defined: `busy_err` is tied to 0 and no error logic is synthesized. Datapath behaviour is identical either way.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32 → `output_block` = 3243f6a8885a308d313198a2e0370734, `valid` exactly 10 cycles after the `start` edge.
- FIPS-197 App. C.1: key 000102…0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a → 00112233445566778899aabbccddeeff. Then issue a back-to-back `start` in the `valid` cycle with the App. B ciphertext → both results correct; second `valid` comes 11 cycles after the first.
- `start` pulsed at cycles 3 and 7 of a running block → result unchanged. With `AES_DEC_BUSY_ERR_EN`, `busy_err`=1 from the first pulse until the next accepted `start`. Without the macro, `busy_err` stays 0.
- `key_ready`=0 with `start`=1 for 5 cycles → `ready` stays 1, no `valid`, `busy_err` stays 0. Raise `key_ready` → the block is accepted.
- `reset_n` dropped at round 5 → outputs go to reset values immediately. A fresh App. B run after release decrypts correctly.
- Round-trip: 100 random key/plaintext pairs through `aes_encipher_block`, then this block → plaintext recovered exactly every time.
